// File: rtl/laser_scan_ctrl.sv
// ---------------------------------------------------------------------------
// laser_scan_ctrl
//
// Scan scheduler for the two-circle laser coverage problem. It alternately
// re-optimises circle 1 (with circle 2 held) and circle 2 (with circle 1
// held). Each sweep visits all 256 candidate centers on the 16x16 grid. For
// every candidate it streams the whole point store and counts the points
// covered by the union of the candidate circle and the fixed circle
// (radius 4). The run stops after an iteration that does not improve the
// count, or after MAX_ITER iterations.
//
// Parameters:
//   NPTS      number of points in the store (1..63)
//   MAX_ITER  maximum alternation iterations (C1 sweep + C2 sweep each)
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   START      start pulse, sampled only while idle
//   PT_RD      point-store read strobe
//   PT_ADDR    point-store read address
//   PT_X/PT_Y  point coordinates, valid the cycle after the PT_RD cycle
//   C1X..C2Y   current circle centers
//   COUNT      points covered by the union of both circles
//   BUSY       high from INIT through FINISH
//   DONE       one-cycle completion pulse
// ---------------------------------------------------------------------------
module laser_scan_ctrl #(
    parameter int unsigned NPTS     = 40,
    parameter int unsigned MAX_ITER = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    output logic       PT_RD,
    output logic [5:0] PT_ADDR,
    input  logic [3:0] PT_X,
    input  logic [3:0] PT_Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic [5:0] COUNT,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_SCAN1  = 3'd2;
    localparam logic [2:0] S_SCAN2  = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    // Slot cycle index range is 0..NPTS+1, so it needs 7 bits for NPTS=63.
    localparam logic [6:0] NPTS_C    = 7'(NPTS);
    localparam logic [6:0] LAST_CYC  = 7'(NPTS + 1);
    localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

    // Exact radius-4 test: 4-bit abs differences, 8-bit squares, 9-bit sum.
    function automatic logic in_reach(input logic [3:0] ax, input logic [3:0] ay,
                                      input logic [3:0] px, input logic [3:0] py);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        logic [8:0] sum;
        dx  = (ax >= px) ? (ax - px) : (px - ax);
        dy  = (ay >= py) ? (ay - py) : (py - ay);
        sx  = {4'b0, dx} * {4'b0, dx};
        sy  = {4'b0, dy} * {4'b0, dy};
        sum = {1'b0, sx} + {1'b0, sy};
        return sum <= 9'd16;
    endfunction

    logic [2:0] state_q,    state_d;
    logic [6:0] cyc_q,      cyc_d;
    logic [3:0] cand_x_q,   cand_x_d;
    logic [3:0] cand_y_q,   cand_y_d;
    logic [5:0] acc_q,      acc_d;
    logic [5:0] best_cnt_q, best_cnt_d;
    logic [3:0] best_x_q,   best_x_d;
    logic [3:0] best_y_q,   best_y_d;
    logic [3:0] c1x_q,      c1x_d;
    logic [3:0] c1y_q,      c1y_d;
    logic [3:0] c2x_q,      c2x_d;
    logic [3:0] c2y_q,      c2y_d;
    logic [5:0] count_q,    count_d;
    logic [5:0] prev_q,     prev_d;
    logic [7:0] iter_q,     iter_d;
    logic       pt_rd_q,    pt_rd_d;
    logic [5:0] pt_addr_q,  pt_addr_d;
    logic       rd_dly_q,   rd_dly_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;

    logic [3:0] fix_x;
    logic [3:0] fix_y;
    logic       point_hit;
    logic       slot_end;
    logic       sweep_end;
    logic       better;
    logic [5:0] win_cnt;
    logic [3:0] win_x;
    logic [3:0] win_y;
    logic       scan_next;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        acc_d      = acc_q;
        best_cnt_d = best_cnt_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        c1x_d      = c1x_q;
        c1y_d      = c1y_q;
        c2x_d      = c2x_q;
        c2y_d      = c2y_q;
        count_d    = count_q;
        prev_d     = prev_q;
        iter_d     = iter_q;
        done_d     = 1'b0;

        // The circle not being swept stays fixed for the whole sweep.
        fix_x     = (state_q == S_SCAN2) ? c1x_q : c2x_q;
        fix_y     = (state_q == S_SCAN2) ? c1y_q : c2y_q;
        point_hit = in_reach(cand_x_q, cand_y_q, PT_X, PT_Y) ||
                    in_reach(fix_x, fix_y, PT_X, PT_Y);

        slot_end  = (cyc_q == LAST_CYC);
        sweep_end = slot_end && (cand_x_q == 4'hF) && (cand_y_q == 4'hF);

        // Strictly greater keeps the earliest candidate on ties.
        better  = (acc_q > best_cnt_q);
        win_cnt = better ? acc_q    : best_cnt_q;
        win_x   = better ? cand_x_q : best_x_q;
        win_y   = better ? cand_y_q : best_y_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_INIT;
                end
            end

            S_INIT: begin
                c1x_d      = '0;
                c1y_d      = '0;
                c2x_d      = '0;
                c2y_d      = '0;
                count_d    = '0;
                prev_d     = '0;
                iter_d     = '0;
                cyc_d      = '0;
                cand_x_d   = '0;
                cand_y_d   = '0;
                acc_d      = '0;
                best_cnt_d = '0;
                best_x_d   = '0;
                best_y_d   = '0;
                state_d    = S_SCAN1;
            end

            S_SCAN1, S_SCAN2: begin
                // rd_dly_q marks the cycle in which PT_X/PT_Y carry a datum.
                if (rd_dly_q && point_hit) begin
                    acc_d = acc_q + 6'd1;
                end
                if (slot_end) begin
                    cyc_d      = '0;
                    acc_d      = '0;
                    best_cnt_d = win_cnt;
                    best_x_d   = win_x;
                    best_y_d   = win_y;
                    // 4-bit increments wrap to (0,0) exactly at sweep end.
                    cand_x_d   = cand_x_q + 4'd1;
                    if (cand_x_q == 4'hF) begin
                        cand_y_d = cand_y_q + 4'd1;
                    end
                    if (sweep_end) begin
                        best_cnt_d = '0;
                        best_x_d   = '0;
                        best_y_d   = '0;
                        count_d    = win_cnt;
                        if (state_q == S_SCAN1) begin
                            c1x_d   = win_x;
                            c1y_d   = win_y;
                            state_d = S_SCAN2;
                        end else begin
                            c2x_d   = win_x;
                            c2y_d   = win_y;
                            state_d = S_CHECK;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + 7'd1;
                end
            end

            S_CHECK: begin
                iter_d = iter_q + 8'd1;
                if ((count_q == prev_q) || (iter_q + 8'd1 == MAX_ITER_C)) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    prev_d  = count_q;
                    state_d = S_SCAN1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read strobe and address are registered from the next slot cycle so
        // that they line up with cyc_q in the cycle they are visible.
        scan_next = (state_d == S_SCAN1) || (state_d == S_SCAN2);
        pt_rd_d   = scan_next && (cyc_d < NPTS_C);
        pt_addr_d = pt_rd_d ? cyc_d[5:0] : '0;
        rd_dly_d  = pt_rd_q;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            acc_q      <= '0;
            best_cnt_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            c1x_q      <= '0;
            c1y_q      <= '0;
            c2x_q      <= '0;
            c2y_q      <= '0;
            count_q    <= '0;
            prev_q     <= '0;
            iter_q     <= '0;
            pt_rd_q    <= 1'b0;
            pt_addr_q  <= '0;
            rd_dly_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            acc_q      <= acc_d;
            best_cnt_q <= best_cnt_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            c1x_q      <= c1x_d;
            c1y_q      <= c1y_d;
            c2x_q      <= c2x_d;
            c2y_q      <= c2y_d;
            count_q    <= count_d;
            prev_q     <= prev_d;
            iter_q     <= iter_d;
            pt_rd_q    <= pt_rd_d;
            pt_addr_q  <= pt_addr_d;
            rd_dly_q   <= rd_dly_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign PT_RD   = pt_rd_q;
    assign PT_ADDR = pt_addr_q;
    assign C1X     = c1x_q;
    assign C1Y     = c1y_q;
    assign C2X     = c2x_q;
    assign C2Y     = c2y_q;
    assign COUNT   = count_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
module tb_laser_scan_ctrl;

    localparam int NP = 4;
    localparam int MI = 3;
    localparam int S  = NP + 2;     // cycles per candidate slot
    localparam int SW = 256 * S;    // cycles per sweep
    localparam int L  = 2 * SW + 1; // cycles per iteration

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       PT_RD;
    logic [5:0] PT_ADDR;
    logic [3:0] PT_X = '0;
    logic [3:0] PT_Y = '0;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic [5:0] COUNT;
    logic       BUSY;
    logic       DONE;

    always #5 CLK = ~CLK;

    laser_scan_ctrl #(.NPTS(NP), .MAX_ITER(MI)) u_dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .PT_RD  (PT_RD),
        .PT_ADDR(PT_ADDR),
        .PT_X   (PT_X),
        .PT_Y   (PT_Y),
        .C1X    (C1X),
        .C1Y    (C1Y),
        .C2X    (C2X),
        .C2Y    (C2Y),
        .COUNT  (COUNT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    // Point store: synchronous read, datum valid the cycle after PT_RD.
    logic [3:0] mem_x [NP];
    logic [3:0] mem_y [NP];
    always @(posedge CLK) begin
        if (PT_RD && (int'(PT_ADDR) < NP)) begin
            PT_X <= mem_x[PT_ADDR];
            PT_Y <= mem_y[PT_ADDR];
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit in_rst = 1'b1;
    bit run_on = 1'b0;
    int t_start = 0;
    int k_run = 0;
    int res_x [2*MI];
    int res_y [2*MI];
    int res_n [2*MI];
    int held_c1x = 0, held_c1y = 0, held_c2x = 0, held_c2y = 0, held_cnt = 0;
    int fin_c1x = 0, fin_c1y = 0, fin_c2x = 0, fin_c2y = 0, fin_cnt = 0;
    int done_seen = -1;
    int done_cnt = 0;

    function automatic bit reach(input int ax, input int ay, input int px, input int py);
        return ((ax - px) * (ax - px) + (ay - py) * (ay - py)) <= 16;
    endfunction

    // Best center for the swept circle given the fixed one; first maximum wins.
    task automatic best_center(input int fx, input int fy,
                               output int bx, output int by, output int bc);
        int n;
        bx = 0; by = 0; bc = 0;
        for (int cy = 0; cy < 16; cy++) begin
            for (int cx = 0; cx < 16; cx++) begin
                n = 0;
                for (int i = 0; i < NP; i++) begin
                    if (reach(cx, cy, int'(mem_x[i]), int'(mem_y[i])) ||
                        reach(fx, fy, int'(mem_x[i]), int'(mem_y[i])))
                        n++;
                end
                if (n > bc) begin
                    bc = n; bx = cx; by = cy;
                end
            end
        end
    endtask

    task automatic model_run();
        int c1x, c1y, c2x, c2y, cnt, prev, it, s;
        c1x = 0; c1y = 0; c2x = 0; c2y = 0; prev = 0; it = 0; s = 0; cnt = 0;
        while (1) begin
            best_center(c2x, c2y, c1x, c1y, cnt);
            res_x[s] = c1x; res_y[s] = c1y; res_n[s] = cnt; s++;
            best_center(c1x, c1y, c2x, c2y, cnt);
            res_x[s] = c2x; res_y[s] = c2y; res_n[s] = cnt; s++;
            it++;
            if (cnt == prev || it == MI) break;
            prev = cnt;
        end
        k_run = it;
        fin_c1x = c1x; fin_c1y = c1y; fin_c2x = c2x; fin_c2y = c2y; fin_cnt = cnt;
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin : cmp
        int n, m, r, sc, e_rd, e_busy, e_done;
        int e_c1x, e_c1y, e_c2x, e_c2y, e_cnt;
        forever begin
            @(negedge CLK);
            e_rd = 0; e_busy = 0; e_done = 0; sc = 0;
            e_c1x = held_c1x; e_c1y = held_c1y; e_c2x = held_c2x; e_c2y = held_c2y;
            e_cnt = held_cnt;
            if (in_rst) begin
                e_c1x = 0; e_c1y = 0; e_c2x = 0; e_c2y = 0; e_cnt = 0;
            end else if (run_on) begin
                n = cyc - t_start;
                if (n == 0) begin
                    e_busy = 1;
                end else if (n > 0) begin
                    m = n - 1;
                    e_c1x = 0; e_c1y = 0; e_c2x = 0; e_c2y = 0; e_cnt = 0;
                    for (int s = 0; s < 2 * k_run; s++) begin
                        if (m >= (s / 2) * L + (s % 2 + 1) * SW) begin
                            if (s % 2 == 0) begin
                                e_c1x = res_x[s]; e_c1y = res_y[s];
                            end else begin
                                e_c2x = res_x[s]; e_c2y = res_y[s];
                            end
                            e_cnt = res_n[s];
                        end
                    end
                    if (m < k_run * L) begin
                        e_busy = 1;
                        r = m % L;
                        if (r < 2 * SW) begin
                            sc = r % S;
                            e_rd = (sc < NP) ? 1 : 0;
                        end
                    end else if (m == k_run * L) begin
                        e_busy = 1;
                        e_done = 1;
                    end
                end
            end
            chk("pt_rd", int'(PT_RD), e_rd);
            if (e_rd == 1) chk("pt_addr", int'(PT_ADDR), sc);
            chk("c1x", int'(C1X), e_c1x);
            chk("c1y", int'(C1Y), e_c1y);
            chk("c2x", int'(C2X), e_c2x);
            chk("c2y", int'(C2Y), e_c2y);
            chk("count", int'(COUNT), e_cnt);
            chk("busy", int'(BUSY), e_busy);
            chk("done", int'(DONE), e_done);
            if (DONE === 1'b1) begin
                done_cnt++;
                if (done_seen < 0) done_seen = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_until(input int c);
        while (cyc < c) @(posedge CLK);
    endtask

    task automatic fill_same(input int x, input int y);
        for (int i = 0; i < NP; i++) begin
            mem_x[i] = 4'(x); mem_y[i] = 4'(y);
        end
    endtask

    task automatic start_run();
        @(negedge CLK);
        #2;
        if (run_on) begin
            held_c1x = fin_c1x; held_c1y = fin_c1y; held_c2x = fin_c2x;
            held_c2y = fin_c2y; held_cnt = fin_cnt;
        end
        model_run();
        t_start = cyc + 1;
        done_seen = -1;
        done_cnt = 0;
        run_on = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        #2 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic finish_run();
        wait_until(t_start + k_run * L + 6);
        chk("done_once", done_cnt, 1);
        chk("done_time", done_seen - t_start, 1 + k_run * L);
    endtask

    task automatic check_33();
        chk("lit_k_33", k_run, 2);
        chk("lit_c1_33", int'({C1X, C1Y}), 8'h10);
        chk("lit_c2_33", int'({C2X, C2Y}), 8'h00);
        chk("lit_cnt_33", int'(COUNT), NP);
        chk("lit_done_33", done_seen - t_start, 6147);
    endtask

    initial begin : stim
        fill_same(0, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #2 RST_N = 1'b1;
        in_rst = 1'b0;
        repeat (20) @(posedge CLK);

        // All points at (3,3), with a START pulse while busy.
        fill_same(3, 3);
        start_run();
        wait_until(t_start + 500);
        pulse_start();
        finish_run();
        check_33();

        // Two clusters: (2,2) and (12,12).
        for (int i = 0; i < NP; i++) begin
            mem_x[i] = (i < NP / 2) ? 4'd2 : 4'd12;
            mem_y[i] = (i < NP / 2) ? 4'd2 : 4'd12;
        end
        start_run();
        finish_run();
        chk("lit_c1_clu", int'({C1X, C1Y}), 8'hC8);
        chk("lit_c2_clu", int'({C2X, C2Y}), 8'h00);
        chk("lit_cnt_clu", int'(COUNT), NP);

        // Reset asserted in the middle of SCAN2.
        fill_same(3, 3);
        start_run();
        wait_until(t_start + 1 + SW + 40);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        in_rst = 1'b1;
        run_on = 1'b0;
        held_c1x = 0; held_c1y = 0; held_c2x = 0; held_c2y = 0; held_cnt = 0;
        #1;
        chk("rst_c1", int'({C1X, C1Y}), 0);
        chk("rst_c2", int'({C2X, C2Y}), 0);
        chk("rst_cnt", int'(COUNT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_rd", int'(PT_RD), 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #2 RST_N = 1'b1;
        in_rst = 1'b0;
        repeat (5) @(posedge CLK);
        start_run();
        finish_run();
        check_33();

        // Random point sets.
        for (int run = 0; run < 3; run++) begin
            for (int i = 0; i < NP; i++) begin
                mem_x[i] = 4'($urandom_range(0, 15));
                mem_y[i] = 4'($urandom_range(0, 15));
            end
            repeat (3) @(posedge CLK);
            start_run();
            finish_run();
        end

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
